ebpf_fetch: RTL and testbench

//  Instruction-fetch front end upstream of the eBPF cpu core. Walks program memory from a start PC,

---
 rtl/ebpf_pkg.sv | 27 ++
 rtl/ebpf_fetch_if.sv | 22 ++
 rtl/ebpf_fetch_fifo.sv | 78 +++++++
 rtl/ebpf_fetch.sv | 187 ++++++++++++++++++
 tb/tb_ebpf_fetch.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ebpf_pkg.sv
// Shared eBPF fetch definitions: opcodes, slot field offsets, fetch FSM states, slot field helpers.
package ebpf_pkg;

    localparam logic [7:0] OP_LDDW = 8'h18;
    localparam logic [7:0] OP_EXIT = 8'h95;

    localparam int OPC_LSB = 0;
    localparam int DST_LSB = 8;
    localparam int SRC_LSB = 12;
    localparam int OFF_LSB = 16;
    localparam int IMM_LSB = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_t;

    function automatic logic [7:0] slot_opcode(input logic [63:0] slot);
        return slot[OPC_LSB +: 8];
    endfunction

    function automatic logic [31:0] slot_imm(input logic [63:0] slot);
        return slot[IMM_LSB +: 32];
    endfunction

endpackage

// File: rtl/ebpf_fetch_if.sv
// Instruction handoff bus from the fetch front end to core decode (valid/ready).
interface ebpf_fetch_if #(
    parameter int IMEM_AW = 12
) ();
    logic               insn_valid;
    logic               insn_ready;
    logic [IMEM_AW-1:0] insn_pc;
    logic [63:0]        insn;
    logic [31:0]        insn_imm_hi;
    logic               insn_wide;
    logic               insn_err;

    modport master (
        output insn_valid, insn_pc, insn, insn_imm_hi, insn_wide, insn_err,
        input  insn_ready
    );

    modport slave (
        input  insn_valid, insn_pc, insn, insn_imm_hi, insn_wide, insn_err,
        output insn_ready
    );
endinterface

// File: rtl/ebpf_fetch_fifo.sv
// Prefetch buffer of {err, pc, slot} entries; exposes the two oldest entries so lddw can pop both at once.
module ebpf_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 12,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic            push_err,
    input  logic [PC_W-1:0] push_pc,
    input  logic [63:0]     push_data,
    input  logic            pop1,
    input  logic            pop2,
    output logic            head_err,
    output logic [PC_W-1:0] head_pc,
    output logic [63:0]     head_data,
    output logic            next_err,
    output logic [63:0]     next_data,
    output logic [CW-1:0]   count
);
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
    logic [CW-1:0] count_q, count_d, pop_n;

    logic            err_q  [DEPTH];
    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [63:0]     data_q [DEPTH];

    assign rd_next = rd_ptr_q + 1'b1;
    assign pop_n   = pop2 ? CW'(2) : CW'(pop1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop2)      rd_ptr_d = rd_next + 1'b1;
            else if (pop1) rd_ptr_d = rd_next;
            count_d = count_q + CW'(push) - pop_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            err_q[wr_ptr_q]  <= push_err;
            pc_q[wr_ptr_q]   <= push_pc;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_err  = err_q[rd_ptr_q];
    assign head_pc   = pc_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign next_err  = err_q[rd_next];
    assign next_data = data_q[rd_next];
    assign count     = count_q;

endmodule

// File: rtl/ebpf_fetch.sv
// eBPF instruction fetch: PC walk, prefetch, lddw merge, redirect flush with epoch tagging.
// Optional EBPF_FETCH_PERF_EN adds saturating stall/flush counters.
module ebpf_fetch
    import ebpf_pkg::*;
#(
    parameter int IMEM_AW    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [IMEM_AW-1:0] start_pc,
    input  logic [IMEM_AW:0]   prog_len,
    input  logic               halt_req,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [63:0]        imem_rdata,
    input  logic               redirect_vld,
    input  logic [IMEM_AW-1:0] redirect_pc,
    ebpf_fetch_if.master       insn_if,
`ifdef EBPF_FETCH_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    output logic               busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d, infl_pc_q, infl_pc_d;
    logic epoch_q, epoch_d, infl_q, infl_d, infl_err_q, infl_err_d;
    logic infl_epoch_q, infl_epoch_d, stall_q, stall_d;

    logic [CW-1:0]      fifo_cnt, occ;
    logic               head_err, next_err;
    logic [IMEM_AW-1:0] head_pc;
    logic [63:0]        head_data, next_data;
    logic run, oob, halt, redir, issue, push, flush;
    logic head_lddw, out_valid, out_wide, out_err, fire;

    assign run   = (state_q == ST_RUN);
    assign oob   = ({1'b0, pc_q} >= prog_len);
    assign halt  = (state_q != ST_IDLE) && halt_req;
    assign redir = run && redirect_vld && !halt_req;
    assign occ   = fifo_cnt + CW'(infl_q);
    assign issue = run && !halt_req && !stall_q && (occ < CW'(FIFO_DEPTH));
    // A read issued under the previous epoch is dropped when it lands after a redirect.
    assign push  = run && infl_q && (infl_epoch_q == epoch_q);
    assign flush = halt || redir;

    assign head_lddw = (slot_opcode(head_data) == OP_LDDW);
    assign out_valid = run && (fifo_cnt != '0) && (!head_lddw || fifo_cnt >= CW'(2));
    assign out_wide  = out_valid && head_lddw;
    assign out_err   = out_valid && (head_err || (head_lddw && next_err));
    assign fire      = out_valid && insn_if.insn_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epoch_d      = epoch_q;
        stall_d      = stall_q;
        infl_d       = 1'b0;
        infl_err_d   = infl_err_q;
        infl_pc_d    = infl_pc_q;
        infl_epoch_d = infl_epoch_q;
        if (issue) begin
            pc_d         = pc_q + 1'b1;
            infl_d       = 1'b1;
            infl_err_d   = oob;
            infl_pc_d    = pc_q;
            infl_epoch_d = epoch_q;
            if (oob) stall_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_pc;
                    stall_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                end else begin
                    if (redir) begin
                        pc_d    = redirect_pc;
                        epoch_d = ~epoch_q;
                        stall_d = 1'b0;
                    end
                    if (fire && out_err) state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (halt_req) begin
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            epoch_q      <= 1'b0;
            stall_q      <= 1'b0;
            infl_q       <= 1'b0;
            infl_err_q   <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epoch_q      <= epoch_d;
            stall_q      <= stall_d;
            infl_q       <= infl_d;
            infl_err_q   <= infl_err_d;
            infl_pc_q    <= infl_pc_d;
            infl_epoch_q <= infl_epoch_d;
        end
    end

    ebpf_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PC_W  (IMEM_AW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_err  (infl_err_q),
        .push_pc   (infl_pc_q),
        .push_data (infl_err_q ? 64'd0 : imem_rdata),
        .pop1      (fire && !out_wide),
        .pop2      (fire && out_wide),
        .head_err  (head_err),
        .head_pc   (head_pc),
        .head_data (head_data),
        .next_err  (next_err),
        .next_data (next_data),
        .count     (fifo_cnt)
    );

    assign imem_rd_en          = issue && !oob;
    assign imem_addr           = pc_q;
    assign busy                = (state_q != ST_IDLE);
    assign insn_if.insn_valid  = out_valid;
    assign insn_if.insn_pc     = out_valid ? head_pc : '0;
    assign insn_if.insn        = out_valid ? head_data : '0;
    assign insn_if.insn_wide   = out_wide;
    assign insn_if.insn_imm_hi = out_wide ? slot_imm(next_data) : '0;
    assign insn_if.insn_err    = out_err;

`ifdef EBPF_FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_IDLE && start) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (out_valid && !insn_if.insn_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (redir && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ebpf_fetch.sv
// Directed bench for ebpf_fetch: straight-line, lddw, redirect, backpressure, lddw-at-end, reset mid-run.
module tb_ebpf_fetch;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          redirect_vld = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW:0]   prog_len = '0;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [63:0]   imem_rdata;
    logic          busy;
`ifdef EBPF_FETCH_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

    ebpf_fetch_if #(.IMEM_AW(AW)) insn_if ();

    ebpf_fetch #(.IMEM_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_pc     (start_pc),
        .prog_len     (prog_len),
        .halt_req     (halt_req),
        .imem_rd_en   (imem_rd_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .insn_if      (insn_if),
`ifdef EBPF_FETCH_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .busy         (busy)
    );

    always #5 clock = ~clock;

    logic [63:0] mem [0:(1<<AW)-1];
    always @(posedge clock) imem_rdata <= imem_rd_en ? mem[imem_addr] : 64'hBADC_0DE0_BADC_0DE0;

    typedef struct {
        int          cyc;
        logic [AW-1:0] pc;
        logic [63:0] insn;
        logic [31:0] hi;
        logic        wide;
        logic        err;
    } hs_t;

    hs_t hs_q[$];
    int  cyc_cnt = 0;
    int  rd_cnt  = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clock) begin
        if (insn_if.insn_valid && insn_if.insn_ready) begin
            hs_q.push_back('{cyc_cnt, insn_if.insn_pc, insn_if.insn, insn_if.insn_imm_hi,
                             insn_if.insn_wide, insn_if.insn_err});
            $display("HS cyc=%0d pc=%0d insn=%h wide=%0d hi=%h err=%0d", cyc_cnt, insn_if.insn_pc,
                     insn_if.insn, insn_if.insn_wide, insn_if.insn_imm_hi, insn_if.insn_err);
        end
        if (imem_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            check_eq("rd_in_range", 64'({1'b0, imem_addr} < prog_len), 64'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] spc, input logic [AW:0] plen, output int scyc);
        start_pc = spc;
        prog_len = plen;
        start    = 1'b1;
        scyc     = cyc_cnt;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic do_halt();
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        hs_q.delete();
    endtask

    task automatic wait_hs(input string tag, input int n, input int limit);
        int k = 0;
        while (hs_q.size() < n && k < limit) begin
            tick(1);
            k++;
        end
        check_eq(tag, 64'(hs_q.size() >= n), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int r0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 64'd0;
        insn_if.insn_ready = 1'b0;

        // Reset state
        tick(3);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", insn_if.insn_valid, 0);
        check_eq("rst_rd_en", imem_rd_en, 0);
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_insn", insn_if.insn, 0);
        check_eq("rst_err", insn_if.insn_err, 0);
        reset = 1'b0;
        tick(1);

        // 1: straight line, then err entry at pc 4
        for (int i = 0; i < 4; i++) mem[i] = {32'(100 + i), 24'h0, 8'hb7};
        insn_if.insn_ready = 1'b1;
        r0 = rd_cnt;
        do_start(12'd0, 13'd4, s);
        wait_hs("t1_wait", 5, 30);
        for (int i = 0; i < 5; i++) begin
            if (i < hs_q.size()) begin
                check_eq($sformatf("t1_pc%0d", i), hs_q[i].pc, 64'(i));
                check_eq($sformatf("t1_insn%0d", i), hs_q[i].insn, (i < 4) ? mem[i] : 64'd0);
                check_eq($sformatf("t1_err%0d", i), hs_q[i].err, 64'(i == 4));
                check_eq($sformatf("t1_cyc%0d", i), 64'(hs_q[i].cyc), 64'(s + 3 + i));
            end
        end
        tick(5);
        check_eq("t1_err_busy", busy, 1);
        check_eq("t1_err_valid", insn_if.insn_valid, 0);
        check_eq("t1_reads", 64'(rd_cnt - r0), 64'd4);
        do_halt();
        check_eq("t1_halt_busy", busy, 0);

        // 2: lddw merge
        mem[0] = 64'h0000_1234_0000_0118;
        mem[1] = 64'hDEAD_BEEF_0000_0000;
        mem[2] = 64'h0000_0007_0000_00b7;
        do_start(12'd0, 13'd3, s);
        wait_hs("t2_wait", 3, 30);
        if (hs_q.size() >= 3) begin
            check_eq("t2_pc0", hs_q[0].pc, 0);
            check_eq("t2_wide0", hs_q[0].wide, 1);
            check_eq("t2_hi0", hs_q[0].hi, 64'hDEADBEEF);
            check_eq("t2_insn0", hs_q[0].insn, 64'h0000_1234_0000_0118);
            check_eq("t2_err0", hs_q[0].err, 0);
            check_eq("t2_pc1", hs_q[1].pc, 2);
            check_eq("t2_wide1", hs_q[1].wide, 0);
            check_eq("t2_hi1", hs_q[1].hi, 0);
            check_eq("t2_pc2", hs_q[2].pc, 3);
            check_eq("t2_err2", hs_q[2].err, 1);
        end
        do_halt();

        // 3: redirect with 3 buffered + 1 in flight
        for (int i = 0; i < 16; i++) mem[i] = {32'(i), 24'h0, 8'hb7};
        insn_if.insn_ready = 1'b0;
        r0 = rd_cnt;
        do_start(12'd0, 13'd16, s);
        tick(4);
        check_eq("t3_pre_valid", insn_if.insn_valid, 1);
        check_eq("t3_pre_pc", insn_if.insn_pc, 0);
        check_eq("t3_pre_reads", 64'(rd_cnt - r0), 64'd4);
        redirect_vld = 1'b1;
        redirect_pc  = 12'd7;
        tick(1);
        redirect_vld = 1'b0;
        check_eq("t3_flushed_valid", insn_if.insn_valid, 0);
        insn_if.insn_ready = 1'b1;
        wait_hs("t3_wait", 3, 30);
        for (int i = 0; i < 3; i++) begin
            if (i < hs_q.size()) begin
                check_eq($sformatf("t3_pc%0d", i), hs_q[i].pc, 64'(7 + i));
                check_eq($sformatf("t3_insn%0d", i), hs_q[i].insn, mem[7 + i]);
            end
        end
        do_halt();

        // 4: backpressure for 10 cycles
        insn_if.insn_ready = 1'b0;
        r0 = rd_cnt;
        do_start(12'd2, 13'd16, s);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("t4_hold_valid%0d", i), insn_if.insn_valid, 1);
            check_eq($sformatf("t4_hold_pc%0d", i), insn_if.insn_pc, 2);
            check_eq($sformatf("t4_hold_insn%0d", i), insn_if.insn, mem[2]);
            tick(1);
        end
        check_eq("t4_reads_bounded", 64'((rd_cnt - r0) <= DEPTH), 64'd1);
        insn_if.insn_ready = 1'b1;
        wait_hs("t4_wait", 6, 40);
        for (int i = 0; i < 6; i++) begin
            if (i < hs_q.size()) begin
                check_eq($sformatf("t4_pc%0d", i), hs_q[i].pc, 64'(2 + i));
                check_eq($sformatf("t4_insn%0d", i), hs_q[i].insn, mem[2 + i]);
            end
        end
        do_halt();

        // 5: lddw at the last slot
        mem[0] = 64'h0000_0055_0000_0018;
        r0 = rd_cnt;
        do_start(12'd0, 13'd1, s);
        wait_hs("t5_wait", 1, 30);
        if (hs_q.size() >= 1) begin
            check_eq("t5_pc", hs_q[0].pc, 0);
            check_eq("t5_wide", hs_q[0].wide, 1);
            check_eq("t5_err", hs_q[0].err, 1);
            check_eq("t5_insn", hs_q[0].insn, 64'h0000_0055_0000_0018);
            check_eq("t5_hi", hs_q[0].hi, 0);
        end
        tick(3);
        check_eq("t5_err_busy", busy, 1);
        check_eq("t5_err_valid", insn_if.insn_valid, 0);
        check_eq("t5_reads", 64'(rd_cnt - r0), 64'd1);
        do_halt();
        check_eq("t5_halt_busy", busy, 0);

        // 6: reset mid-run with a read in flight
        do_start(12'd5, 13'd16, s);
        tick(1);
        check_eq("t6_rd_before", imem_rd_en, 1);
        reset = 1'b1;
        tick(1);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_valid", insn_if.insn_valid, 0);
        check_eq("t6_rd_en", imem_rd_en, 0);
        reset = 1'b0;
        hs_q.delete();
        tick(2);
        check_eq("t6_idle_valid", insn_if.insn_valid, 0);
        do_start(12'd5, 13'd16, s);
        wait_hs("t6_wait", 2, 30);
        for (int i = 0; i < 2; i++) begin
            if (i < hs_q.size()) begin
                check_eq($sformatf("t6_pc%0d", i), hs_q[i].pc, 64'(5 + i));
                check_eq($sformatf("t6_insn%0d", i), hs_q[i].insn, mem[5 + i]);
            end
        end
        do_halt();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
